// File: rtl/bram_master_pkg.sv
// Shared definitions for the BRAM port-A master.
//  - state_e   : controller states (zero-fill, then normal traffic)
//  - be_width  : byte-enable width for a given data width
//  - cnt_width : width of a counter able to hold 0..depth inclusive
package bram_master_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Response FIFO for bram_porta_master.
//  First-word-fall-through: the head entry is visible on rdata_o whenever
//  valid_o is high and stays stable until it is popped.
// Ports:
//  clk_i        clock
//  rst_i        synchronous active-high reset (empties the FIFO)
//  push_i       write push_data_i (ignored when full)
//  push_data_i  data to enqueue
//  pop_i        remove the head entry (ignored when empty)
//  valid_o      FIFO not empty
//  rdata_o      head entry, zero when empty
//  count_o      number of stored entries
module bram_rsp_fifo
    import bram_master_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = cnt_width(4)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count_q gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head-of-queue outputs, forced to zero when nothing is stored.
    always_comb begin
        valid_o = (count_q != {CNT_W{1'b0}});
        count_o = count_q;
        if (valid_o) begin
            rdata_o = mem_q[rd_ptr_q];
        end else begin
            rdata_o = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/bram_porta_master.sv
// Initiator for the port-A native interface of a block RAM.
//  Turns a valid/ready request stream (byte-masked writes and reads) into
//  BRAM port cycles, tracks the BRAM read latency with a tag pipe and returns
//  read data in order through a response FIFO. Optionally zero-fills the whole
//  memory after reset before accepting traffic.
// Ports:
//  clka, rsta            clock, synchronous active-high reset
//  req_valid/req_ready   request handshake; req_we, req_be, req_addr, req_wdata payload
//  rsp_valid/rsp_ready   response handshake; rsp_rdata read data
//  busy                  high while the zero-fill runs
//  ena, wea, addra, dina BRAM port drive (registered)
//  douta                 BRAM read data
module bram_porta_master
    import bram_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned READ_LAT       = 1,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy,
    output logic                  ena,
    output logic [DATA_W/8-1:0]   wea,
    output logic [ADDR_W-1:0]     addra,
    output logic [DATA_W-1:0]     dina,
    input  logic [DATA_W-1:0]     douta
);

    localparam int unsigned BE_W  = be_width(DATA_W);
    localparam int unsigned CNT_W = cnt_width(RSP_DEPTH);
    localparam int unsigned TAG_W = READ_LAT + 1;
    localparam state_e      ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                ena_q, ena_d;
    logic [BE_W-1:0]     wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                req_ready_q, req_ready_d;

    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [CNT_W-1:0]    fifo_count_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [CNT_W-1:0]    inflight_nxt_s;

    assign accept_s = req_valid && req_ready_q && (state_q == ST_RUN);
    // The oldest tag bit lines up with douta carrying that read's data.
    assign push_s   = tag_q[TAG_W-1];
    assign pop_s    = rsp_valid && rsp_ready;

    // FSM next state, clear counter and BRAM port next values.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ena_d     = 1'b0;
        wea_d     = {BE_W{1'b0}};
        addra_d   = addra_q;
        dina_d    = dina_q;
        case (state_q)
            ST_CLEAR: begin
                ena_d     = 1'b1;
                wea_d     = {BE_W{1'b1}};
                addra_d   = clr_cnt_q;
                dina_d    = {DATA_W{1'b0}};
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                if (accept_s) begin
                    ena_d   = 1'b1;
                    wea_d   = req_we ? req_be : {BE_W{1'b0}};
                    addra_d = req_addr;
                    dina_d  = req_wdata;
                end else begin
                    ena_d = 1'b0;
                    wea_d = {BE_W{1'b0}};
                end
            end
            default: begin
                state_d   = ST_RESET;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Read tag pipe and credit look-ahead so req_ready can be a register.
    always_comb begin
        tag_d          = {tag_q[TAG_W-2:0], accept_s && !req_we};
        count_nxt_s    = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        inflight_nxt_s = {CNT_W{1'b0}};
        for (int i = 0; i < TAG_W; i++) begin
            inflight_nxt_s = inflight_nxt_s + CNT_W'(tag_d[i]);
        end
        if (state_d == ST_RUN) begin
            req_ready_d = (inflight_nxt_s + count_nxt_s) < CNT_W'(RSP_DEPTH);
        end else begin
            req_ready_d = 1'b0;
        end
    end

    // State, port and credit registers.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_RESET;
            clr_cnt_q   <= {ADDR_W{1'b0}};
            ena_q       <= 1'b0;
            wea_q       <= {BE_W{1'b0}};
            addra_q     <= {ADDR_W{1'b0}};
            dina_q      <= {DATA_W{1'b0}};
            tag_q       <= {TAG_W{1'b0}};
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ena_q       <= ena_d;
            wea_q       <= wea_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            tag_q       <= tag_d;
            req_ready_q <= req_ready_d;
        end
    end

    bram_rsp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk_i       (clka),
        .rst_i       (rsta),
        .push_i      (push_s),
        .push_data_i (douta),
        .pop_i       (pop_s),
        .valid_o     (rsp_valid),
        .rdata_o     (rsp_rdata),
        .count_o     (fifo_count_s)
    );

    assign req_ready = req_ready_q;
    assign busy      = (state_q == ST_CLEAR);
    assign ena       = ena_q;
    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;

endmodule

// File: tb/tb_bram_porta_master.sv
// Bench for bram_porta_master with an attached BRAM model (read latency 1).
// A reference memory updated at request acceptance predicts read data; the
// expected values are queued and a negedge monitor pops and compares them.
module tb_bram_porta_master;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        ena;
    logic [3:0]  wea;
    logic [7:0]  addra;
    logic [31:0] dina;
    logic [31:0] douta = 32'h0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int resp_total = 0;
    int resp_cyc_q[$];
    logic [31:0] resp_data_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] bram [256];
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = 32'h0;
    bit          rdy_rand = 1'b0;

    always #5 clka = ~clka;

    bram_porta_master #(
        .ADDR_W(8), .DATA_W(32), .READ_LAT(1), .RSP_DEPTH(4), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clka(clka), .rsta(rsta),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
    );

    // Block RAM model, read-first, one cycle read latency.
    always @(posedge clka) begin
        cyc <= cyc + 1;
        if (ena) begin
            for (int b = 0; b < 4; b++) begin
                if (wea[b]) bram[addra][8*b +: 8] <= dina[8*b +: 8];
            end
            douta <= bram[addra];
        end
    end

    // Random consumer back-pressure when enabled.
    always @(posedge clka) begin
        #1;
        if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard monitor: response compare, hold check, then model update on accept.
    always @(negedge clka) begin
        if (rsta) begin
            exp_q.delete();
            stall_prev = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(rsp_valid && rsp_rdata == stall_data)) begin
                    failures++;
                    $display("FAIL rsp_hold: valid=%0b data=%h, required valid=1 data=%h",
                             rsp_valid, rsp_rdata, stall_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                resp_total++;
                resp_cyc_q.push_back(cyc);
                resp_data_q.push_back(rsp_rdata);
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: got %h, required no response", rsp_rdata);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e) begin
                        failures++;
                        $display("FAIL rsp_data: got %h, required %h", rsp_rdata, e);
                    end
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            stall_data = rsp_rdata;
            if (req_valid && req_ready) begin
                if (req_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the request was accepted.
    task automatic issue(input logic we, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] data);
        int w;
        w = 0;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = data;
        @(negedge clka);
        while (!req_ready && w < 200) begin
            w++;
            @(negedge clka);
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: req_ready=0 for %0d cycles, required 1", w);
        end
        @(posedge clka); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 500) begin
            @(negedge clka);
            w++;
        end
        if (w >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        @(posedge clka); #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clka);
            lat++;
        end while (!rsp_valid && lat < 20);
    endtask

    // Called at posedge+1: holds reset, checks reset values, then follows the zero-fill.
    task automatic reset_and_clear();
        int busy_n, seen, bad, rspv;
        rsta = 1'b1;
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("rst_ena", 32'(ena), 32'h0);
        chk("rst_wea", 32'(wea), 32'h0);
        chk("rst_addra", 32'(addra), 32'h0);
        chk("rst_dina", dina, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        @(posedge clka); #1;
        rsta = 1'b0;
        busy_n = 0; seen = 0; bad = 0; rspv = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clka);
            if (busy) busy_n++;
            if (rsp_valid) rspv++;
            if (ena) begin
                if (!(wea == 4'hF && dina == 32'h0 && addra == seen[7:0])) bad++;
                seen++;
            end
            if (!busy && seen >= 256) break;
        end
        chk("clear_busy_cycles", 32'(busy_n), 32'd256);
        chk("clear_writes", 32'(seen), 32'd256);
        chk("clear_bad_writes", 32'(bad), 32'd0);
        chk("rsp_during_clear", 32'(rspv), 32'd0);
        chk("ready_after_clear", 32'(req_ready), 32'h1);
        @(posedge clka); #1;
    endtask

    initial begin
        int lat, idx, stalls, base;
        logic [31:0] d;

        // 1: reset and zero-fill
        @(posedge clka); #1;
        reset_and_clear();

        // 2: write then read the same address on the next cycle
        issue(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 8'h10, 32'h0);
        wait_rsp(lat);
        chk("rd_latency", 32'(lat - 1), 32'd2);
        chk("rd_deadbeef", rsp_rdata, 32'hDEADBEEF);
        @(posedge clka); #1;
        wait_drain();

        // 3: byte-masked merge
        issue(1'b1, 4'b0011, 8'h20, 32'h0000CAFE);
        issue(1'b1, 4'b1100, 8'h20, 32'h12340000);
        issue(1'b1, 4'b0000, 8'h20, 32'hFFFFFFFF);
        issue(1'b0, 4'h0, 8'h20, 32'h0);
        wait_rsp(lat);
        chk("rd_merge", rsp_rdata, 32'h1234CAFE);
        @(posedge clka); #1;
        wait_drain();

        // 4: credit limit with consumer stalled
        for (int i = 0; i < 6; i++) issue(1'b1, 4'hF, 8'h40 + 8'(i), $urandom);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; idx = 0;
        base = resp_total;
        for (int c = 0; c < 20; c++) begin
            @(negedge clka);
            if (req_ready) idx++;
            @(posedge clka); #1;
            if (idx < 6) req_addr = 8'h40 + idx[7:0]; else req_valid = 1'b0;
        end
        chk("credit_accepted", 32'(idx), 32'd4);
        chk("credit_ready_low", 32'(req_ready), 32'h0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 6; c++) begin
            @(negedge clka);
            if (req_ready) idx++;
            @(posedge clka); #1;
            if (idx < 6) req_addr = 8'h40 + idx[7:0]; else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("credit_total", 32'(idx), 32'd6);
        wait_drain();
        chk("credit_responses", 32'(resp_total - base), 32'd6);

        // 5: reset with two reads in flight
        issue(1'b0, 4'h0, 8'h10, 32'h0);
        issue(1'b0, 4'h0, 8'h20, 32'h0);
        reset_and_clear();

        // 6: streaming reads at full rate
        for (int i = 0; i < 8; i++) issue(1'b1, 4'hF, 8'(i), 32'(i * 3));
        resp_cyc_q.delete();
        resp_data_q.delete();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; idx = 0; stalls = 0;
        for (int c = 0; c < 50 && idx < 8; c++) begin
            @(negedge clka);
            if (req_ready) idx++; else stalls++;
            @(posedge clka); #1;
            if (idx < 8) req_addr = idx[7:0]; else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        wait_drain();
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_count", 32'(resp_data_q.size()), 32'd8);
        if (resp_cyc_q.size() == 8) begin
            chk("stream_span", 32'(resp_cyc_q[7] - resp_cyc_q[0]), 32'd7);
            for (int i = 0; i < 8; i++) chk("stream_data", resp_data_q[i], 32'(i * 3));
        end

        // Random mixed traffic with random back-pressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clka); #1;
            end
            d = $urandom;
            issue(1'($urandom_range(0, 1)), 4'($urandom), 8'h80 + 8'($urandom_range(0, 15)), d);
        end
        rdy_rand = 1'b0;
        @(posedge clka); #1;
        rsp_ready = 1'b1;
        wait_drain();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
